mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous data memory between the CPU data port and the debug/test port driven by the board user-test unit.
- The debug port supplies address, write data and write enable from the switches/buttons.
- The block arbitrates per cycle with a burst-limited owner FSM.
- It drives the memory port and returns read data to the requester that issued the read, one cycle later.
- It sits between the CPU core, the user-test unit and the memory macro in the top level.

Parameters:
AW, 16, address width of both requesters and memory.
DW, 32, data width.
MAX_BURST, 4, maximum consecutive grants to one owner while the other requester is waiting (>=1).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU access request; address, we and wdata held stable until granted.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  AW  CPU address.
cpu_wdata  in  DW  CPU write data.
cpu_gnt  out  1  CPU access performed this cycle.
cpu_rvalid  out  1  CPU read data valid (one cycle after a granted read).
cpu_rdata  out  DW  CPU read data.
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug-port equivalents of the CPU inputs.
dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DW  debug-port equivalents of the CPU outputs.
cpu_halt  in  1  CPU is stopped (single-step or halt); debug port gets strict priority.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.
owner  out  2  debug visibility: 00 = IDLE, 01 = CPU, 10 = DBG.

Behaviour:
- Reset values: state IDLE, burst_cnt 0, last_owner DBG (so the CPU wins the first tie), all gnt/rvalid/mem_en/mem_we 0, mem_addr/mem_wdata 0, rdata outputs 0, owner 00.
- Grant is combinational from the current req inputs and the registered state. At most one gnt per cycle. The granted request drives mem_* in the same cycle. mem_en = cpu_gnt | dbg_gnt. When no grant is issued, mem_* hold 0 (mem_we and mem_en forced 0).
- FSM states: IDLE, CPU, DBG. "Requester X wins" means gnt_X=1, next state = X.
  - IDLE, single requester: that requester wins; burst_cnt <= 1.
  - IDLE, both requesting: cpu_halt=1 → DBG wins. Otherwise the requester that is not last_owner wins.
  - CPU/DBG, owner still requesting, other idle: owner granted; burst_cnt saturates at MAX_BURST.
  - CPU/DBG, owner still requesting, other requesting, burst_cnt < MAX_BURST: owner granted; burst_cnt++.
  - CPU/DBG, owner still requesting, other requesting, burst_cnt == MAX_BURST: other requester wins; burst_cnt <= 1.
  - CPU/DBG, owner drops req: other requester wins if requesting (burst_cnt <= 1); otherwise go to IDLE with no grant.
- cpu_halt=1 overrides the burst limit in favour of the debug port. In CPU state with dbg_req=1, DBG wins immediately regardless of burst_cnt. In DBG state, DBG keeps the bus for as long as dbg_req=1.
- last_owner updates to the granted requester on every grant.
- Read return:
  - A granted read registers a 1-bit tag (CPU/DBG) and a pending flag.
  - Next cycle, the tagged rvalid = 1 and its rdata = mem_rdata. The other rdata output holds its last value.
  - Back-to-back reads to alternating requesters return correctly tagged data every cycle.
  - Writes produce no rvalid.
- A granted write is performed in the grant cycle; no response cycle.
- Throughput: one access per cycle. Idle cycles occur only when no requester is active.
- Reset asserted mid-transaction: the pending read is discarded (no rvalid after reset releases) and the FSM returns to IDLE.

Test Plan:
- Reset, then CPU read addr 0x0010 with mem_rdata 0x12345678 → cpu_gnt=1 in cycle 0; cpu_rvalid=1 and cpu_rdata=0x12345678 in cycle 1; dbg_rvalid stays 0.
- Both request from IDLE after reset, cpu_halt=0 → CPU granted first (last_owner reset = DBG); DBG granted next cycle if the CPU drops req.
- CPU holds req continuously, dbg_req held from cycle 0, MAX_BURST=4 → cpu_gnt in cycles 0–3, dbg_gnt in cycle 4, owner=10 in cycle 5.
- cpu_halt=1, CPU in burst at burst_cnt=1, dbg write addr 0x0003 data 0xDEADBEEF → dbg_gnt in the next cycle; mem_we=1, mem_addr=0x0003, mem_wdata=0xDEADBEEF; CPU stalls until dbg_req drops.
- Alternating reads CPU@0x1, DBG@0x2, CPU@0x3 with mem_rdata A, B, C → rvalid routed cpu, dbg, cpu on consecutive cycles with matching data.
- Assert rst the cycle after a granted dbg read → no dbg_rvalid after release; owner=00; first post-reset tie goes to CPU.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU and debug ports with a burst-limited owner FSM.
// Grant is same-cycle; read data returns one cycle later. Losers are held off by withholding gnt.
module mem_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          cpu_halt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CPU  = 2'b01,
        S_DBG  = 2'b10
    } state_t;

    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic          last_dbg;
    logic          give_cpu, give_dbg;
    logic          rd_pend, rd_tag_dbg;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

    always_comb begin
        give_cpu = 1'b0;
        give_dbg = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req && dbg_req) begin
                    if (cpu_halt || !last_dbg) give_dbg = 1'b1;
                    else                       give_cpu = 1'b1;
                end else begin
                    give_cpu = cpu_req;
                    give_dbg = dbg_req;
                end
            end
            S_CPU: begin
                // A halted CPU yields to the debug port regardless of burst count.
                if (cpu_req) begin
                    if (dbg_req && (cpu_halt || burst_cnt == BMAX)) give_dbg = 1'b1;
                    else                                           give_cpu = 1'b1;
                end else begin
                    give_dbg = dbg_req;
                end
            end
            S_DBG: begin
                if (dbg_req) begin
                    if (cpu_req && !cpu_halt && burst_cnt == BMAX) give_cpu = 1'b1;
                    else                                           give_dbg = 1'b1;
                end else begin
                    give_cpu = cpu_req;
                end
            end
            default: ;
        endcase
        if (rst) begin
            give_cpu = 1'b0;
            give_dbg = 1'b0;
        end
    end

    assign cpu_gnt   = give_cpu;
    assign dbg_gnt   = give_dbg;
    assign mem_en    = give_cpu | give_dbg;
    assign mem_we    = give_cpu ? cpu_we    : (give_dbg ? dbg_we    : 1'b0);
    assign mem_addr  = give_cpu ? cpu_addr  : (give_dbg ? dbg_addr  : '0);
    assign mem_wdata = give_cpu ? cpu_wdata : (give_dbg ? dbg_wdata : '0);
    assign owner     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
            last_dbg  <= 1'b1;
        end else if (give_cpu) begin
            state     <= S_CPU;
            burst_cnt <= (state != S_CPU) ? CW'(1) :
                         (burst_cnt == BMAX) ? BMAX : burst_cnt + CW'(1);
            last_dbg  <= 1'b0;
        end else if (give_dbg) begin
            state     <= S_DBG;
            burst_cnt <= (state != S_DBG) ? CW'(1) :
                         (burst_cnt == BMAX) ? BMAX : burst_cnt + CW'(1);
            last_dbg  <= 1'b1;
        end else begin
            state     <= S_IDLE;
            burst_cnt <= '0;
        end
    end

    // Read tag travels with the access so back-to-back reads to alternating ports route correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend     <= 1'b0;
            rd_tag_dbg  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            rd_pend     <= mem_en && !mem_we;
            rd_tag_dbg  <= give_dbg;
            cpu_rdata_q <= cpu_rdata;
            dbg_rdata_q <= dbg_rdata;
        end
    end

    assign cpu_rvalid = rd_pend && !rd_tag_dbg;
    assign dbg_rvalid = rd_pend &&  rd_tag_dbg;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a per-cycle arbitration model.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we, cpu_halt;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_rdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    owner;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .cpu_halt(cpu_halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds the bus (0 none, 1 cpu, 2 dbg), streak length, last winner,
    // who is owed read data this cycle, and the value each rdata port should show.
    int            m_own, m_streak, m_last, m_rv, g_win;
    logic [DW-1:0] m_cpu_rd, m_dbg_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_streak = 0; m_last = 2; m_rv = 0;
        m_cpu_rd = '0; m_dbg_rd = '0;
    endtask

    function automatic int pick_winner();
        bit want [1:2];
        int other;
        want[1] = cpu_req;
        want[2] = dbg_req;
        if (m_own == 0) begin
            if (want[1] && want[2]) return cpu_halt ? 2 : (m_last == 2 ? 1 : 2);
            if (want[1]) return 1;
            if (want[2]) return 2;
            return 0;
        end
        other = 3 - m_own;
        if (!want[m_own]) return want[other] ? other : 0;
        if (!want[other]) return m_own;
        if (cpu_halt) return 2;
        return (m_streak >= MB) ? other : m_own;
    endfunction

    // One clock cycle: inputs are already driven; check outputs, then advance model past the edge.
    task automatic step();
        bit            e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #1;
        if (rst) model_reset();
        g_win = rst ? 0 : pick_winner();
        e_we   = (g_win == 1) ? cpu_we    : (g_win == 2) ? dbg_we    : 1'b0;
        e_addr = (g_win == 1) ? cpu_addr  : (g_win == 2) ? dbg_addr  : '0;
        e_wd   = (g_win == 1) ? cpu_wdata : (g_win == 2) ? dbg_wdata : '0;
        if (m_rv == 1) m_cpu_rd = mem_rdata;
        if (m_rv == 2) m_dbg_rd = mem_rdata;
        chk("cpu_gnt",    32'(cpu_gnt),    32'(g_win == 1));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(g_win == 2));
        chk("mem_en",     32'(mem_en),     32'(g_win != 0));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_addr",   32'(mem_addr),   32'(e_addr));
        chk("mem_wdata",  mem_wdata,       e_wd);
        chk("owner",      32'(owner),      32'(m_own));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv == 1));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv == 2));
        chk("cpu_rdata",  cpu_rdata,       m_cpu_rd);
        chk("dbg_rdata",  dbg_rdata,       m_dbg_rd);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_rv = (g_win != 0 && !e_we) ? g_win : 0;
            if (g_win == 0) begin
                m_own = 0; m_streak = 0;
            end else begin
                m_streak = (g_win == m_own) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
                m_own  = g_win;
                m_last = g_win;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                         input bit h, input logic [DW-1:0] rd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        cpu_halt = h; mem_rdata = rd;
        step();
    endtask

    task automatic idle_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0, $urandom);
    endtask

    initial begin
        model_reset();
        g_win = 0;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        cpu_halt = 0; mem_rdata = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Single CPU read returns next cycle.
        drive(1, 0, 16'h0010, '0, 0, 0, '0, '0, 0, '0);
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0, 32'h12345678);
        idle_cycle();

        // Fresh tie after reset: CPU first, then DBG once CPU drops.
        rst = 1'b1; idle_cycle(); rst = 1'b0;
        drive(1, 0, 16'h0020, '0, 1, 0, 16'h0021, '0, 0, $urandom);
        drive(0, 0, '0, '0, 1, 0, 16'h0021, '0, 0, $urandom);
        idle_cycle();
        idle_cycle();

        // Burst limit: CPU streams, DBG waits from the first cycle.
        rst = 1'b1; idle_cycle(); rst = 1'b0;
        for (int i = 0; i < 7; i++)
            drive(1, 1, 16'(i), $urandom, (g_win != 2 || i == 0), 1, 16'h0100, 32'hA5A5A5A5, 0, $urandom);
        idle_cycle();

        // Halt: CPU owns with streak 1, debug write preempts and keeps the bus.
        drive(1, 0, 16'h0040, '0, 0, 0, '0, '0, 1, $urandom);
        for (int i = 0; i < 4; i++)
            drive(1, 0, 16'h0040, '0, 1, 1, 16'h0003, 32'hDEADBEEF, 1, $urandom);
        drive(1, 0, 16'h0040, '0, 0, 0, '0, '0, 1, $urandom);
        idle_cycle();

        // Alternating reads route data to the right port.
        drive(1, 0, 16'h0001, '0, 0, 0, '0, '0, 0, $urandom);
        drive(0, 0, '0, '0, 1, 0, 16'h0002, '0, 0, 32'hAAAA0001);
        drive(1, 0, 16'h0003, '0, 0, 0, '0, '0, 0, 32'hBBBB0002);
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0, 32'hCCCC0003);
        idle_cycle();

        // Reset right after a granted debug read discards the return.
        drive(0, 0, '0, '0, 1, 0, 16'h0055, '0, 0, $urandom);
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0, 32'h99999999);
        rst = 1'b0;
        idle_cycle();
        drive(1, 0, 16'h0066, '0, 1, 0, 16'h0077, '0, 0, $urandom);
        idle_cycle();

        // Random traffic: each port holds its request until the model grants it.
        cpu_req = 0; dbg_req = 0;
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req && $urandom_range(0, 3) != 0) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = $urandom;
            end
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = 16'($urandom); dbg_wdata = $urandom;
            end
            cpu_halt  = ((i / 60) % 3 == 2);
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            step();
            if (g_win == 1) cpu_req = 0;
            if (g_win == 2) dbg_req = 0;
            if (rst) begin cpu_req = 0; dbg_req = 0; end
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
